addsub_control: RTL and testbench

Multi-cycle control unit sitting directly upstream of the ADD/SUB datapath.
- Accepts 32-bit RV64 instructions over a valid/ready handshake.
- Decodes ADD, SUB, ADDI, LD and SD.
- Drives the datapath's register selectors, immediate, sub, R_type, I_type, WE_RF and WE_MEM in a fixed 4-state sequence.
- Maintains the program counter presented to instruction fetch.

---
 rtl/addsub_pkg.sv | 12 +
 rtl/addsub_decoder.sv | 47 ++++
 rtl/addsub_control.sv | 128 ++++++++++++
 tb/tb_addsub_control.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: opcode/funct constants and FSM state encoding for the ADD/SUB controller
package addsub_pkg;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_DWORD = 3'b011;
  localparam logic [6:0] F7_ADD   = 7'b0000000;
  localparam logic [6:0] F7_SUB   = 7'b0100000;
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WRITE} state_e;
endpackage

// File: rtl/addsub_decoder.sv
// addsub_decoder: maps an instruction word to datapath selectors, per-field update enables and a legal flag
// Ports: ir_i instruction word; legal_o supported encoding; *_en_o field is defined for this instruction;
//        rs1_o/rs2_o/rd_o/imm_o selector values; sub_o/r_type_o/i_type_o/store_o control bits
module addsub_decoder
  import addsub_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic        legal_o,
  output logic        rs1_en_o,
  output logic        rs2_en_o,
  output logic        rd_en_o,
  output logic        imm_en_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [11:0] imm_o,
  output logic        sub_o,
  output logic        r_type_o,
  output logic        i_type_o,
  output logic        store_o
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic is_add, is_sub, is_addi, is_ld, is_sd;
  assign op = ir_i[6:0];
  assign f3 = ir_i[14:12];
  assign f7 = ir_i[31:25];
  assign is_add  = op == OP_R && f3 == F3_ADD && f7 == F7_ADD;
  assign is_sub  = op == OP_R && f3 == F3_ADD && f7 == F7_SUB;
  assign is_addi = op == OP_IMM && f3 == F3_ADD;
  assign is_ld   = op == OP_LOAD && f3 == F3_DWORD;
  assign is_sd   = op == OP_STORE && f3 == F3_DWORD;
  assign legal_o  = is_add | is_sub | is_addi | is_ld | is_sd;
  assign rs1_en_o = is_add | is_sub | is_sd;
  assign rs2_en_o = legal_o;
  assign rd_en_o  = legal_o & ~is_sd;
  assign imm_en_o = is_addi | is_ld | is_sd;
  // Stores route the data register to Ra and the base to Rb; I-types route the base to Rb
  assign rs1_o    = is_sd ? ir_i[24:20] : ir_i[19:15];
  assign rs2_o    = (is_add | is_sub) ? ir_i[24:20] : ir_i[19:15];
  assign rd_o     = ir_i[11:7];
  assign imm_o    = is_sd ? {ir_i[31:25], ir_i[11:7]} : ir_i[31:20];
  assign sub_o    = is_sub;
  assign r_type_o = is_add | is_sub | is_addi;
  assign i_type_o = is_addi | is_ld | is_sd;
  assign store_o  = is_sd;
endmodule

// File: rtl/addsub_control.sv
// addsub_control: 4-state controller driving the ADD/SUB datapath and the fetch PC
// Ports: CLK/RST_N clock and sync active-low reset; instr_valid/instr_ready/instr instruction handshake;
//        pc_out next fetch address; rs1/rs2/rd/immediate/sub/R_type/I_type/WE_RF/WE_MEM datapath controls;
//        busy not idle; illegal one-cycle unsupported-instruction pulse;
//        retired 32-bit retired-instruction counter, present only when PERF_CNT_EN is defined
module addsub_control
  import addsub_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [11:0]     immediate,
  output logic            sub,
  output logic            R_type,
  output logic            I_type,
  output logic            WE_RF,
  output logic            WE_MEM,
  output logic            busy,
`ifdef PERF_CNT_EN
  output logic [31:0]     retired,
`endif
  output logic            illegal
);
  state_e state_q;
  logic [31:0] ir_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [4:0] rs1_q, rs2_q, rd_q;
  logic [11:0] imm_q;
  logic sub_q, r_type_q, i_type_q, store_q, we_rf_q, we_mem_q, illegal_q, ready_q, busy_q;
  logic legal, rs1_en, rs2_en, rd_en, imm_en, d_sub, d_r_type, d_i_type, d_store;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic [11:0] d_imm;
  addsub_decoder u_dec (
    .ir_i(ir_q), .legal_o(legal), .rs1_en_o(rs1_en), .rs2_en_o(rs2_en), .rd_en_o(rd_en),
    .imm_en_o(imm_en), .rs1_o(d_rs1), .rs2_o(d_rs2), .rd_o(d_rd), .imm_o(d_imm),
    .sub_o(d_sub), .r_type_o(d_r_type), .i_type_o(d_i_type), .store_o(d_store)
  );
  assign pc_d = pc_q + XLEN'(4);
  always_ff @(posedge CLK)
    if (!RST_N) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      pc_q      <= PC_RESET;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      sub_q     <= 1'b0;
      r_type_q  <= 1'b0;
      i_type_q  <= 1'b0;
      store_q   <= 1'b0;
      we_rf_q   <= 1'b0;
      we_mem_q  <= 1'b0;
      illegal_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: if (instr_valid) begin
          ir_q    <= instr;
          pc_q    <= pc_d;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= DECODE;
        end
        DECODE: if (legal) begin
          // Fields an instruction does not define keep their previous value
          if (rs1_en) rs1_q <= d_rs1;
          if (rs2_en) rs2_q <= d_rs2;
          if (rd_en) rd_q <= d_rd;
          if (imm_en) imm_q <= d_imm;
          sub_q    <= d_sub;
          r_type_q <= d_r_type;
          i_type_q <= d_i_type;
          store_q  <= d_store;
          state_q  <= EXEC;
        end else begin
          illegal_q <= 1'b1;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        EXEC: begin
          // Enables are registered here so they are visible exactly during WRITE
          we_rf_q  <= !store_q && rd_q != 5'd0;
          we_mem_q <= store_q;
          state_q  <= WRITE;
        end
        WRITE: begin
          we_rf_q  <= 1'b0;
          we_mem_q <= 1'b0;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
`ifdef PERF_CNT_EN
  logic [31:0] retired_q;
  always_ff @(posedge CLK)
    if (!RST_N) retired_q <= '0;
    else if (state_q == WRITE) retired_q <= retired_q + 32'd1;
  assign retired = retired_q;
`endif
  assign instr_ready = ready_q;
  assign pc_out      = pc_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign rd          = rd_q;
  assign immediate   = imm_q;
  assign sub         = sub_q;
  assign R_type      = r_type_q;
  assign I_type      = i_type_q;
  assign WE_RF       = we_rf_q;
  assign WE_MEM      = we_mem_q;
  assign busy        = busy_q;
  assign illegal     = illegal_q;
endmodule

// File: tb/tb_addsub_control.sv
// tb_addsub_control: directed plus randomized instruction checks of addsub_control against a field-level model
module tb_addsub_control;
  logic CLK = 1'b0, RST_N = 1'b0, instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic instr_ready, sub, R_type, I_type, WE_RF, WE_MEM, busy, illegal;
  logic [63:0] pc_out;
  logic [4:0] rs1, rs2, rd;
  logic [11:0] immediate;
`ifdef PERF_CNT_EN
  logic [31:0] retired;
`endif
  addsub_control #(.XLEN(64), .PC_RESET(64'd0)) dut (
    .CLK(CLK), .RST_N(RST_N), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .pc_out(pc_out), .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate), .sub(sub),
    .R_type(R_type), .I_type(I_type), .WE_RF(WE_RF), .WE_MEM(WE_MEM), .busy(busy),
`ifdef PERF_CNT_EN
    .retired(retired),
`endif
    .illegal(illegal)
  );
  always #5 CLK = ~CLK;
  int passed = 0, total = 0;
  logic [63:0] m_pc;
  logic [4:0] m_rs1, m_rs2, m_rd;
  logic [11:0] m_imm;
  logic m_sub, m_r, m_i;
  int unsigned m_ret;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  // 0 ADD, 1 SUB, 2 ADDI, 3 LD, 4 SD, 5 unsupported
  function automatic int kind_of(input logic [31:0] w);
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) return 0;
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) return 1;
    if (op == 7'h13 && f3 == 3'd0) return 2;
    if (op == 7'h03 && f3 == 3'd3) return 3;
    if (op == 7'h23 && f3 == 3'd3) return 4;
    return 5;
  endfunction
  task automatic model_reset();
    m_pc = 64'd0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_imm = 0;
    m_sub = 0; m_r = 0; m_i = 0; m_ret = 0;
  endtask
  task automatic chk_sel(input string t);
    chk({t, "_rs1"}, 64'(rs1), 64'(m_rs1));
    chk({t, "_rs2"}, 64'(rs2), 64'(m_rs2));
    chk({t, "_rd"}, 64'(rd), 64'(m_rd));
    chk({t, "_imm"}, 64'(immediate), 64'(m_imm));
    chk({t, "_sub"}, 64'(sub), 64'(m_sub));
    chk({t, "_rtype"}, 64'(R_type), 64'(m_r));
    chk({t, "_itype"}, 64'(I_type), 64'(m_i));
  endtask
  task automatic chk_idle(input string t);
    chk({t, "_ready"}, 64'(instr_ready), 64'd1);
    chk({t, "_busy"}, 64'(busy), 64'd0);
    chk({t, "_we_rf"}, 64'(WE_RF), 64'd0);
    chk({t, "_we_mem"}, 64'(WE_MEM), 64'd0);
    chk({t, "_pc"}, pc_out, m_pc);
`ifdef PERF_CNT_EN
    chk({t, "_retired"}, 64'(retired), 64'(m_ret));
`endif
  endtask
  task automatic run(input string t, input logic [31:0] w);
    int k;
    logic [4:0] f_rd, f_a, f_b;
    k = kind_of(w);
    f_rd = w[11:7]; f_a = w[19:15]; f_b = w[24:20];
    chk({t, "_c0_ready"}, 64'(instr_ready), 64'd1);
    instr = w; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0; instr = $urandom;
    m_pc = m_pc + 64'd4;
    chk({t, "_c1_ready"}, 64'(instr_ready), 64'd0);
    chk({t, "_c1_busy"}, 64'(busy), 64'd1);
    chk({t, "_c1_we"}, 64'({WE_RF, WE_MEM, illegal}), 64'd0);
    chk({t, "_c1_pc"}, pc_out, m_pc);
    step();
    if (k == 5) begin
      chk({t, "_ill_pulse"}, 64'(illegal), 64'd1);
      chk_idle({t, "_ill"});
      chk_sel({t, "_ill"});
      step();
      chk({t, "_ill_drop"}, 64'(illegal), 64'd0);
      chk_idle({t, "_ill_after"});
      return;
    end
    case (k)
      0, 1: begin m_rs1 = f_a; m_rs2 = f_b; m_rd = f_rd; m_sub = (k == 1); m_r = 1; m_i = 0; end
      2, 3: begin m_rs2 = f_a; m_rd = f_rd; m_imm = w[31:20]; m_sub = 0; m_r = (k == 2); m_i = 1; end
      default: begin m_rs1 = f_b; m_rs2 = f_a; m_imm = {w[31:25], w[11:7]}; m_sub = 0; m_r = 0; m_i = 1; end
    endcase
    chk({t, "_c2_ready"}, 64'(instr_ready), 64'd0);
    chk({t, "_c2_we"}, 64'({WE_RF, WE_MEM, illegal}), 64'd0);
    chk_sel({t, "_c2"});
    step();
    chk({t, "_c3_we_rf"}, 64'(WE_RF), 64'(k != 4 && f_rd != 0));
    chk({t, "_c3_we_mem"}, 64'(WE_MEM), 64'(k == 4));
    chk({t, "_c3_ready"}, 64'(instr_ready), 64'd0);
    chk({t, "_c3_busy"}, 64'(busy), 64'd1);
    step();
    m_ret++;
    chk_idle({t, "_c4"});
    chk_sel({t, "_c4"});
  endtask
  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, d;
    logic [11:0] im;
    a = 5'($urandom); b = 5'($urandom); d = 5'($urandom); im = 12'($urandom);
    case ($urandom_range(0, 5))
      0: return {7'h00, b, a, 3'd0, d, 7'h33};
      1: return {7'h20, b, a, 3'd0, d, 7'h33};
      2: return {im, a, 3'd0, d, 7'h13};
      3: return {im, a, 3'd3, d, 7'h03};
      4: return {im[11:5], b, a, 3'd3, im[4:0], 7'h23};
      default: return $urandom;
    endcase
  endfunction
  initial begin
    RST_N = 1'b0;
    step();
    model_reset();
    chk_idle("reset");
    chk_sel("reset");
    chk("reset_illegal", 64'(illegal), 64'd0);
    RST_N = 1'b1;
    run("add", 32'h002081B3);
    run("sub", 32'h402081B3);
    run("addi", 32'h00C00293);
    run("ld", 32'h00813303);
    run("sd", 32'h00513823);
    run("illegal", 32'hFFFFFFFF);
    run("add_rd0", 32'h00208033);
    for (int n = 0; n < 60; n++) run("rand", rand_instr());
    instr = 32'h00513823; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    RST_N = 1'b0;
    step();
    model_reset();
    chk_idle("midrst");
    chk_sel("midrst");
    chk("midrst_illegal", 64'(illegal), 64'd0);
    RST_N = 1'b1;
    step();
    chk("midrst_hold_we", 64'({WE_RF, WE_MEM}), 64'd0);
    run("post_add", 32'h002081B3);
    run("post_ld", 32'h00813303);
    run("post_sd", 32'h00513823);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
